parallel_to_serial_lanes: RTL and testbench

- Next-generation parallel-to-serial converter: takes N-bit words over a valid/ready handshake and emits them as N/L consecutive L-bit beats.
- Runtime-selectable MSB-first or LSB-first beat order.
- Holding buffer behind the shifter so back-to-back words stream with no idle beat between them.
- Sits between word-oriented datapath logic and narrow serial/lane outputs of the user project.

---
 rtl/parallel_to_serial_lanes.sv | 161 ++++++++++++++++
 tb/tb_parallel_to_serial_lanes.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial_lanes.sv
// parallel_to_serial_lanes: N-bit words in over valid/ready, out as N/L L-bit beats.
// A shifter stage backed by one holding register keeps back-to-back words gap-free.

module parallel_to_serial_lanes #(
   parameter int N = 8,
   parameter int L = 1
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_enable,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_data,
   input  logic         i_last,
   input  logic         i_lsb_first,
   output logic         o_valid,
   output logic [L-1:0] o_data,
   output logic         o_first,
   output logic         o_last,
   output logic         o_busy
);

   localparam int BEATS = N / L;
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

   if (N < 1 || L < 1 || L > N || (N % L) != 0) begin : g_param_check
      $error("parallel_to_serial_lanes: L must be in 1..N and divide N");
   end

   typedef struct packed {
      logic [N-1:0] data;
      logic         last;
      logic         lsb;
   } word_t;

   word_t         in_word;
   word_t         sh_q;
   word_t         sh_d;
   word_t         hold_q;
   word_t         hold_d;
   logic          sh_act_q;
   logic          sh_act_d;
   logic          hold_full_q;
   logic          hold_full_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_inc;
   logic [L-1:0]  data_q;
   logic [L-1:0]  data_d;
   logic          first_q;
   logic          first_d;
   logic          last_q;
   logic          last_d;
   logic          accept;
   logic          sh_final;
   logic          to_shift;

   // Beat k of a stored word, honouring the order captured at acceptance.
   function automatic logic [L-1:0] beat_of(
      input word_t         w,
      input logic [CW-1:0] k
   );
      logic [N-1:0] sft;
      int           idx;
      idx = w.lsb ? int'(k) : (BEATS - 1 - int'(k));
      sft = w.data >> (idx * L);
      return sft[L-1:0];
   endfunction

   assign in_word  = '{data: i_data, last: i_last, lsb: i_lsb_first};
   assign o_ready  = i_enable && !i_reset && !hold_full_q;
   assign accept   = i_valid && o_ready;
   assign sh_final = sh_act_q && (cnt_q == LAST_CNT);
   assign to_shift = accept && (!sh_act_q || sh_final);
   assign cnt_inc  = cnt_q + CW'(1);

   always_comb begin
      sh_d        = sh_q;
      sh_act_d    = sh_act_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      first_d     = 1'b0;
      last_d      = 1'b0;

      if (sh_final && hold_full_q) begin
         hold_full_d = 1'b0;
      end
      if (accept && !to_shift) begin
         hold_d      = in_word;
         hold_full_d = 1'b1;
      end

      unique case (1'b1)
         (sh_act_q && !sh_final): begin
            cnt_d  = cnt_inc;
            data_d = beat_of(sh_q, cnt_inc);
            last_d = sh_q.last && (cnt_inc == LAST_CNT);
         end
         (sh_final && hold_full_q): begin
            sh_d     = hold_q;
            sh_act_d = 1'b1;
            cnt_d    = '0;
            data_d   = beat_of(hold_q, '0);
            first_d  = 1'b1;
            last_d   = hold_q.last && (BEATS == 1);
         end
         to_shift: begin
            sh_d     = in_word;
            sh_act_d = 1'b1;
            cnt_d    = '0;
            data_d   = beat_of(in_word, '0);
            first_d  = 1'b1;
            last_d   = i_last && (BEATS == 1);
         end
         default: begin
            sh_act_d = 1'b0;
         end
      endcase
   end

   // Disable flushes everything but leaves the last beat on o_data.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sh_q        <= '0;
         hold_q      <= '0;
         sh_act_q    <= 1'b0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
         data_q      <= '0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
      end else if (!i_enable) begin
         sh_q        <= '0;
         hold_q      <= '0;
         sh_act_q    <= 1'b0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         sh_q        <= sh_d;
         hold_q      <= hold_d;
         sh_act_q    <= sh_act_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         first_q     <= first_d;
         last_q      <= last_d;
      end
   end

   assign o_valid = sh_act_q;
   assign o_data  = data_q;
   assign o_first = first_q;
   assign o_last  = last_q;
   assign o_busy  = sh_act_q || hold_full_q;

endmodule

// File: tb/tb_parallel_to_serial_lanes.sv
// tb_parallel_to_serial_lanes: three configurations (8/1, 8/2, 4/4) checked
// against a beat-queue reference model plus directed expectations.

module tb_parallel_to_serial_lanes;

   typedef struct {
      logic [7:0] data;
      bit         first;
      bit         last;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] en;
   logic [2:0] vld;
   logic [2:0] lst;
   logic [2:0] lsbf;
   logic [7:0] din [3];
   logic [2:0] rdy;
   logic [2:0] ov;
   logic [2:0] of;
   logic [2:0] ol;
   logic [2:0] ob;
   logic [0:0] od0;
   logic [1:0] od1;
   logic [3:0] od2;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   beat_t      q0 [$];
   beat_t      q1 [$];
   beat_t      q2 [$];
   bit [2:0]   mv;
   bit [2:0]   mf;
   bit [2:0]   ml;
   logic [7:0] md [3];

   always #5 clk = ~clk;

   parallel_to_serial_lanes #(.N(8), .L(1)) u_w8l1 (
      .i_clock(clk), .i_reset(rst), .i_enable(en[0]),
      .i_valid(vld[0]), .o_ready(rdy[0]), .i_data(din[0]),
      .i_last(lst[0]), .i_lsb_first(lsbf[0]), .o_valid(ov[0]),
      .o_data(od0), .o_first(of[0]), .o_last(ol[0]), .o_busy(ob[0])
   );

   parallel_to_serial_lanes #(.N(8), .L(2)) u_w8l2 (
      .i_clock(clk), .i_reset(rst), .i_enable(en[1]),
      .i_valid(vld[1]), .o_ready(rdy[1]), .i_data(din[1]),
      .i_last(lst[1]), .i_lsb_first(lsbf[1]), .o_valid(ov[1]),
      .o_data(od1), .o_first(of[1]), .o_last(ol[1]), .o_busy(ob[1])
   );

   parallel_to_serial_lanes #(.N(4), .L(4)) u_w4l4 (
      .i_clock(clk), .i_reset(rst), .i_enable(en[2]),
      .i_valid(vld[2]), .o_ready(rdy[2]), .i_data(din[2][3:0]),
      .i_last(lst[2]), .i_lsb_first(lsbf[2]), .o_valid(ov[2]),
      .o_data(od2), .o_first(of[2]), .o_last(ol[2]), .o_busy(ob[2])
   );

   function automatic int nn(int k);
      return (k == 2) ? 4 : 8;
   endfunction

   function automatic int ll(int k);
      return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
   endfunction

   function automatic int be(int k);
      return nn(k) / ll(k);
   endfunction

   function automatic int qsz(int k);
      if (k == 0) return q0.size();
      if (k == 1) return q1.size();
      return q2.size();
   endfunction

   task automatic qpush(int k, beat_t b);
      if (k == 0) q0.push_back(b);
      else if (k == 1) q1.push_back(b);
      else q2.push_back(b);
   endtask

   task automatic qclear(int k);
      if (k == 0) q0.delete();
      else if (k == 1) q1.delete();
      else q2.delete();
   endtask

   task automatic qpop(int k, output beat_t b);
      if (k == 0) b = q0.pop_front();
      else if (k == 1) b = q1.pop_front();
      else b = q2.pop_front();
   endtask

   // A whole unstarted word waiting means the holding slot is taken.
   function automatic bit exp_rdy(int k);
      return en[k] && !rst && (qsz(k) < be(k));
   endfunction

   function automatic bit exp_busy(int k);
      return mv[k] || (qsz(k) >= be(k));
   endfunction

   function automatic logic [7:0] odat(int k);
      if (k == 0) return {7'd0, od0};
      if (k == 1) return {6'd0, od1};
      return {4'd0, od2};
   endfunction

   task automatic model_step(int k);
      bit    acc;
      int    w;
      int    b;
      int    idx;
      beat_t bt;
      acc = vld[k] && exp_rdy(k);
      if (rst || !en[k]) begin
         qclear(k);
         mv[k] = 0;
         mf[k] = 0;
         ml[k] = 0;
         if (rst) md[k] = '0;
      end else begin
         if (acc) begin
            w = int'(din[k]) % (1 << nn(k));
            b = be(k);
            for (int i = 0; i < b; i++) begin
               idx = lsbf[k] ? i : (b - 1 - i);
               bt.data = 8'((w >> (idx * ll(k))) % (1 << ll(k)));
               bt.first = (i == 0);
               bt.last = lst[k] && (i == b - 1);
               qpush(k, bt);
            end
         end
         if (qsz(k) > 0) begin
            qpop(k, bt);
            mv[k] = 1;
            md[k] = bt.data;
            mf[k] = bt.first;
            ml[k] = bt.last;
         end else begin
            mv[k] = 0;
            mf[k] = 0;
            ml[k] = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      #1;
      cyc++;
   endtask

   task automatic idle_all();
      rst  = 1'b0;
      en   = 3'b111;
      vld  = 3'b000;
      lst  = 3'b000;
      lsbf = 3'b000;
      for (int k = 0; k < 3; k++) din[k] = 8'h00;
   endtask

   task automatic test_reset();
      idle_all();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         for (int k = 0; k < 3; k++) begin
            vecs++;
            if (rdy[k] !== 1'b0) begin
               errs++;
               $display("FAIL reset_ready k%0d: got %b want 0", k, rdy[k]);
            end
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            vecs++;
            if ({ov[k], of[k], ol[k], ob[k], odat(k)} !== 12'h000) begin
               errs++;
               $display("FAIL reset_out k%0d: got v%b f%b l%b b%b d%h want 0",
                        k, ov[k], of[k], ol[k], ob[k], odat(k));
            end
         end
      end
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         vecs++;
         if (rdy[k] !== 1'b1) begin
            errs++;
            $display("FAIL reset_release k%0d: got %b want 1", k, rdy[k]);
         end
      end
   endtask

   task automatic test_msb_single();
      logic [7:0] w;
      w = 8'hA5;
      idle_all();
      for (int i = 0; i < 10; i++) begin
         vld[0] = (i == 0);
         din[0] = w;
         #1;
         vecs++;
         if (rdy[0] !== exp_rdy(0)) begin
            errs++;
            $display("FAIL msb_ready @%0d: got %b want %b", cyc, rdy[0], exp_rdy(0));
         end
         tick();
         vecs++;
         if ({ov[0], of[0], ol[0], ob[0], odat(0)} !==
             {mv[0], mf[0], ml[0], exp_busy(0), md[0]}) begin
            errs++;
            $display("FAIL msb_model @%0d: got v%b f%b l%b d%h want v%b f%b l%b d%h",
                     cyc, ov[0], of[0], ol[0], odat(0), mv[0], mf[0], ml[0], md[0]);
         end
         vecs++;
         if (i < 8) begin
            if (ov[0] !== 1'b1 || od0 !== w[7-i] || of[0] !== (i == 0)) begin
               errs++;
               $display("FAIL msb_beat%0d: got v%b d%b f%b want v1 d%b f%b",
                        i, ov[0], od0, of[0], w[7-i], (i == 0));
            end
         end else if (ov[0] !== 1'b0) begin
            errs++;
            $display("FAIL msb_idle%0d: got v%b want v0", i, ov[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      idle_all();
      for (int j = 0; j < 18; j++) begin
         vld[0] = (j < 2);
         din[0] = (j == 0) ? 8'hA5 : 8'h3C;
         lst[0] = (j == 1);
         #1;
         vecs++;
         if (rdy[0] !== ((j < 2) || (j >= 9))) begin
            errs++;
            $display("FAIL b2b_ready t+%0d: got %b want %b", j, rdy[0], (j < 2) || (j >= 9));
         end
         tick();
         vecs++;
         if ({ov[0], of[0], ol[0], ob[0], odat(0)} !==
             {mv[0], mf[0], ml[0], exp_busy(0), md[0]}) begin
            errs++;
            $display("FAIL b2b_model @%0d: got v%b f%b l%b b%b d%h want v%b f%b l%b b%b d%h",
                     cyc, ov[0], of[0], ol[0], ob[0], odat(0),
                     mv[0], mf[0], ml[0], exp_busy(0), md[0]);
         end
         vecs++;
         if (ov[0] !== (j <= 15) || ol[0] !== (j == 15)) begin
            errs++;
            $display("FAIL b2b_frame t+%0d: got v%b l%b want v%b l%b",
                     j + 1, ov[0], ol[0], (j <= 15), (j == 15));
         end
      end
   endtask

   task automatic test_lanes();
      int tl [4] = '{0, 1, 3, 2};
      int tm [4] = '{2, 3, 1, 0};
      int want;
      idle_all();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 6; i++) begin
            vld[1]  = (i == 0);
            din[1]  = 8'hB4;
            lsbf[1] = (i == 0) ? (r == 0) : (r != 0);
            #1;
            vecs++;
            if (rdy[1] !== exp_rdy(1)) begin
               errs++;
               $display("FAIL lanes_ready @%0d: got %b want %b", cyc, rdy[1], exp_rdy(1));
            end
            tick();
            vecs++;
            if ({ov[1], of[1], ol[1], ob[1], odat(1)} !==
                {mv[1], mf[1], ml[1], exp_busy(1), md[1]}) begin
               errs++;
               $display("FAIL lanes_model @%0d: got v%b f%b d%h want v%b f%b d%h",
                        cyc, ov[1], of[1], odat(1), mv[1], mf[1], md[1]);
            end
            if (i < 4) begin
               want = (r == 0) ? tl[i] : tm[i];
               vecs++;
               if (ov[1] !== 1'b1 || odat(1) !== 8'(want)) begin
                  errs++;
                  $display("FAIL lanes_r%0d_beat%0d: got v%b d%0d want v1 d%0d",
                           r, i, ov[1], odat(1), want);
               end
            end
         end
      end
   endtask

   task automatic test_disable();
      logic [7:0] w;
      w = 8'h81;
      idle_all();
      for (int i = 0; i < 15; i++) begin
         en[0]  = (i != 4);
         vld[0] = (i == 0) || (i == 5);
         din[0] = (i == 0) ? 8'hFF : w;
         #1;
         vecs++;
         if (rdy[0] !== exp_rdy(0)) begin
            errs++;
            $display("FAIL dis_ready @%0d: got %b want %b", cyc, rdy[0], exp_rdy(0));
         end
         tick();
         vecs++;
         if ({ov[0], of[0], ol[0], ob[0], odat(0)} !==
             {mv[0], mf[0], ml[0], exp_busy(0), md[0]}) begin
            errs++;
            $display("FAIL dis_model @%0d: got v%b f%b b%b d%h want v%b f%b b%b d%h",
                     cyc, ov[0], of[0], ob[0], odat(0), mv[0], mf[0], exp_busy(0), md[0]);
         end
         if (i == 4) begin
            vecs++;
            if (ov[0] !== 1'b0 || ob[0] !== 1'b0) begin
               errs++;
               $display("FAIL dis_flush: got v%b b%b want v0 b0", ov[0], ob[0]);
            end
         end else if (i >= 5 && i < 13) begin
            vecs++;
            if (ov[0] !== 1'b1 || od0 !== w[12-i] || of[0] !== (i == 5)) begin
               errs++;
               $display("FAIL dis_resend%0d: got v%b d%b f%b want v1 d%b f%b",
                        i - 5, ov[0], od0, of[0], w[12-i], (i == 5));
            end
         end
      end
   endtask

   task automatic test_full_word();
      idle_all();
      for (int i = 0; i < 5; i++) begin
         vld[2] = (i < 3);
         din[2] = 8'(i + 1);
         lst[2] = (i == 2);
         #1;
         vecs++;
         if (rdy[2] !== 1'b1) begin
            errs++;
            $display("FAIL full_ready%0d: got %b want 1", i, rdy[2]);
         end
         tick();
         vecs++;
         if (i < 3) begin
            if (ov[2] !== 1'b1 || od2 !== 4'(i + 1) || of[2] !== 1'b1
                || ol[2] !== (i == 2)) begin
               errs++;
               $display("FAIL full_beat%0d: got v%b d%h f%b l%b want v1 d%h f1 l%b",
                        i, ov[2], od2, of[2], ol[2], 4'(i + 1), (i == 2));
            end
         end else if (ov[2] !== 1'b0 || ob[2] !== 1'b0) begin
            errs++;
            $display("FAIL full_idle%0d: got v%b b%b want v0 b0", i, ov[2], ob[2]);
         end
      end
   endtask

   task automatic test_reset_hold();
      idle_all();
      for (int i = 0; i < 13; i++) begin
         rst    = (i == 3);
         vld[0] = (i < 2);
         din[0] = (i == 0) ? 8'h11 : 8'h22;
         #1;
         vecs++;
         if (rdy[0] !== ((i < 2) || (i >= 4))) begin
            errs++;
            $display("FAIL rsth_ready%0d: got %b want %b", i, rdy[0], (i < 2) || (i >= 4));
         end
         tick();
         vecs++;
         if ({ov[0], of[0], ol[0], ob[0], odat(0)} !==
             {mv[0], mf[0], ml[0], exp_busy(0), md[0]}) begin
            errs++;
            $display("FAIL rsth_model @%0d: got v%b b%b d%h want v%b b%b d%h",
                     cyc, ov[0], ob[0], odat(0), mv[0], exp_busy(0), md[0]);
         end
         if (i == 2) begin
            vecs++;
            if (ob[0] !== 1'b1) begin
               errs++;
               $display("FAIL rsth_busy: got %b want 1", ob[0]);
            end
         end else if (i >= 3) begin
            vecs++;
            if ({ov[0], of[0], ol[0], ob[0], od0} !== 5'b0) begin
               errs++;
               $display("FAIL rsth_clear%0d: got v%b f%b l%b b%b d%b want 0",
                        i, ov[0], of[0], ol[0], ob[0], od0);
            end
         end
      end
   endtask

   task automatic test_random();
      idle_all();
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 149) == 0);
         for (int k = 0; k < 3; k++) begin
            en[k]   = ($urandom_range(0, 39) != 0);
            vld[k]  = ($urandom_range(0, 3) != 0);
            din[k]  = 8'($urandom);
            lst[k]  = 1'($urandom);
            lsbf[k] = 1'($urandom);
         end
         #1;
         for (int k = 0; k < 3; k++) begin
            vecs++;
            if (rdy[k] !== exp_rdy(k)) begin
               errs++;
               $display("FAIL rand_ready k%0d @%0d: got %b want %b",
                        k, cyc, rdy[k], exp_rdy(k));
            end
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            vecs++;
            if ({ov[k], of[k], ol[k], ob[k], odat(k)} !==
                {mv[k], mf[k], ml[k], exp_busy(k), md[k]}) begin
               errs++;
               $display("FAIL rand_out k%0d @%0d: got v%b f%b l%b b%b d%h want v%b f%b l%b b%b d%h",
                        k, cyc, ov[k], of[k], ol[k], ob[k], odat(k),
                        mv[k], mf[k], ml[k], exp_busy(k), md[k]);
            end
         end
      end
      idle_all();
      for (int i = 0; i < 20; i++) tick();
   endtask

   initial begin
      mv = '0;
      mf = '0;
      ml = '0;
      for (int k = 0; k < 3; k++) md[k] = '0;
      test_reset();
      test_msb_single();
      test_back_to_back();
      test_lanes();
      test_disable();
      test_full_word();
      test_reset_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
